div_unit: RTL and testbench

Sequential 32-bit signed divider for the multicycle datapath. Computes quotient into LO and remainder into HI for `div`. Sits upstream of the ALU/HI-LO result-selection muxes, which consume `hi`, `lo` and `div_zero`. A start/done handshake with the control-unit FSM holds the datapath while the divider iterates.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 88 ++++++++
 tb/tb_div_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath types and constants for the multicycle CPU.
package cpu_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Unsigned magnitude of a two's complement word; 0x80000000 maps to itself.
  function automatic logic [WORD_W-1:0] mag(input logic [WORD_W-1:0] x);
    return x[WORD_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract divisor.
module div_step
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] rem,
  input  logic [WORD_W-1:0] quot,
  input  logic [WORD_W-1:0] divisor,
  output logic [WORD_W-1:0] rem_next,
  output logic [WORD_W-1:0] quot_next
);

  logic [WORD_W:0] shifted;
  logic            fits;

  always_comb begin
    shifted   = {rem, quot[WORD_W-1]};
    fits      = (shifted >= {1'b0, divisor});
    // When the trial fails, shifted < divisor so it fits in WORD_W bits.
    rem_next  = fits ? WORD_W'(shifted - {1'b0, divisor}) : shifted[WORD_W-1:0];
    quot_next = {quot[WORD_W-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit signed divider: quotient to lo, remainder to hi,
// with start/done handshake toward the control FSM.
module div_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  div_state_t        state;
  logic [WORD_W-1:0] rem;
  logic [WORD_W-1:0] quot;
  logic [WORD_W-1:0] divisor;
  logic [CNT_W-1:0]  cnt;
  logic              rem_neg;
  logic              quot_neg;
  logic [WORD_W-1:0] rem_next;
  logic [WORD_W-1:0] quot_next;

  div_step u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      cnt      <= '0;
      rem_neg  <= 1'b0;
      quot_neg <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              quot     <= mag(a);
              divisor  <= mag(b);
              rem      <= '0;
              cnt      <= '0;
              rem_neg  <= a[WORD_W-1];
              quot_neg <= a[WORD_W-1] ^ b[WORD_W-1];
              busy     <= 1'b1;
              state    <= CALC;
            end else begin
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          lo    <= quot_neg ? -quot : quot;
          hi    <= rem_neg ? -rem : rem;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against a plain-arithmetic signed division model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Truncating signed division in 64-bit so 0x80000000 / -1 cannot overflow.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  // inject_edge: edge at which a stray start(a=1,b=1) is sampled; reset_edge: edge of reset.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input int inject_edge, input int reset_edge);
    logic [31:0] q;
    logic [31:0] r;
    int done_k;
    int overlap;
    int busy_bad;
    int late_done;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1 start = 1'b0;
    if (b == 32'd0) begin
      @(negedge clk);
      check("dz_pulse", 32'(div_zero), 32'd1);
      check("dz_busy", 32'(busy), 32'd0);
      check("dz_done", 32'(done), 32'd0);
      check("dz_hi_hold", hi, exp_hi);
      check("dz_lo_hold", lo, exp_lo);
      @(negedge clk);
      check("dz_one_cycle", 32'(div_zero), 32'd0);
      return;
    end
    ref_div(a, b, q, r);
    done_k = -1; overlap = 0; busy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done && div_zero) overlap++;
      if (k == inject_edge - 1) begin start = 1'b1; a_in = 32'd1; b_in = 32'd1; end
      if (k == inject_edge) start = 1'b0;
      if (k == reset_edge - 1) reset = 1'b1;
      if (k == reset_edge) begin
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_hi = '0; exp_lo = '0;
        late_done = 0;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          if (done || busy) late_done++;
        end
        check("rst_no_done", 32'(late_done), 32'd0);
        return;
      end
      if (done) begin done_k = k; break; end
      if (!busy) busy_bad++;
    end
    check("done_latency", 32'(done_k), 32'd33);
    check("busy_during", 32'(busy_bad), 32'd0);
    check("done_dz_overlap", 32'(overlap), 32'd0);
    check("lo", lo, q);
    check("hi", hi, r);
    check("busy_after", 32'(busy), 32'd0);
    exp_lo = q; exp_hi = r;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dz", 32'(div_zero), 32'd0);

    do_div(32'd7, 32'd2, -10, -10);
    do_div(32'hFFFF_FFF9, 32'd2, -10, -10);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, -10, -10);
    do_div(32'd5, 32'd0, -10, -10);
    do_div(32'd100, 32'd7, 10, -10);
    do_div(32'd100, 32'd7, -10, 15);
    do_div(32'd9, 32'd3, -10, -10);
    do_div(32'd0, 32'h8000_0000, -10, -10);
    do_div(32'h8000_0000, 32'h8000_0000, -10, -10);
    do_div(32'h7FFF_FFFF, 32'hFFFF_FFFE, -10, -10);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_div(ra, rb, -10, -10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
